int_adder_tree_accumulator: RTL and testbench

- Consumer end of the integer adder-tree reduction path.
- Accepts the stream of partial sums leaving an adder-tree root over a valid/ready handshake.
- Accumulates NUM_BEATS consecutive beats into a wide accumulator, then emits one final sum over a valid/ready output.
- Sits between the adder-tree root and downstream requantisation/writeback logic.

---
 rtl/int_adder_tree_accumulator_pkg.sv | 75 +++++++
 rtl/int_adder_tree_accumulator_output_reg.sv | 44 ++++
 rtl/int_adder_tree_accumulator.sv | 118 +++++++++++
 tb/tb_int_adder_tree_accumulator.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_adder_tree_accumulator_pkg.sv
// Shared helpers for the adder-tree accumulator: beat-counter sizing and
// width-limited saturating adds. The saturating helpers are only called when
// INT_ACC_SATURATE_EN is defined.
package int_acc_pkg;

  // Working width of the saturating helpers; accumulators up to 63 bits wide.
  localparam int SAT_W = 64;

  typedef logic [SAT_W-1:0] word_t;

  typedef struct packed {
    logic  clip;
    word_t sum;
  } sat_res_t;

  // A counter for n beats; never narrower than one bit.
  function automatic int beat_cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Largest unsigned value held in w bits.
  function automatic word_t umax(input int w);
    return (w >= SAT_W) ? '1 : ((word_t'(1) << w) - word_t'(1));
  endfunction

  // Largest signed value held in w bits.
  function automatic word_t smax(input int w);
    return (word_t'(1) << (w - 1)) - word_t'(1);
  endfunction

  // Most negative signed value in w bits, as a w-bit two's-complement pattern.
  function automatic word_t smin(input int w);
    return word_t'(1) << (w - 1);
  endfunction

  // Unsigned add of two w-bit values, clamped to [0, 2^w-1].
  function automatic sat_res_t sat_add_u(input word_t a, input word_t b, input int w);
    logic [SAT_W:0] s;
    sat_res_t r;
    s = {1'b0, a} + {1'b0, b};
    r.clip = (s > {1'b0, umax(w)});
    r.sum  = r.clip ? umax(w) : s[SAT_W-1:0];
    return r;
  endfunction

  // Signed add of two w-bit two's-complement values, clamped to the w-bit range.
  function automatic sat_res_t sat_add_s(input word_t a, input word_t b, input int w);
    logic signed [SAT_W:0] as;
    logic signed [SAT_W:0] bs;
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] mx;
    logic signed [SAT_W:0] mn;
    int sh;
    sat_res_t r;
    sh = SAT_W + 1 - w;
    as = {1'b0, a} << sh;
    as = as >>> sh;
    bs = {1'b0, b} << sh;
    bs = bs >>> sh;
    s  = as + bs;
    mx = {1'b0, smax(w)};
    mn = ~mx;
    r.clip = 1'b0;
    r.sum  = s[SAT_W-1:0];
    if (s > mx) begin
      r.clip = 1'b1;
      r.sum  = smax(w);
    end else if (s < mn) begin
      r.clip = 1'b1;
      r.sum  = smin(w);
    end
    return r;
  endfunction

endpackage

// File: rtl/int_adder_tree_accumulator_output_reg.sv
// Result holding register: out_data/out_valid (and sat_flag when
// INT_ACC_SATURATE_EN is defined). load wins over clear so a result accepted
// downstream in the same cycle a new one completes is replaced, not dropped.
module int_acc_output_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_data,
`ifdef INT_ACC_SATURATE_EN
  input  logic         load_flag,
  output logic         sat_flag,
`endif
  output logic [W-1:0] out_data,
  output logic         out_valid
);

  // Capture a finished sum, or drop valid once it has been taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
    end else if (clear) begin
      out_valid <= 1'b0;
    end
  end

`ifdef INT_ACC_SATURATE_EN
  // Clip indication travels with the data it describes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_flag <= 1'b0;
    end else if (load) begin
      sat_flag <= load_flag;
    end
  end
`endif

endmodule

// File: rtl/int_adder_tree_accumulator.sv
// Adder-tree accumulator: sums NUM_BEATS partial sums from the tree root and
// presents one result over valid/ready. rst is asynchronous, active-low.
// Define INT_ACC_SATURATE_EN to make every add saturate (signed range when
// SIGN_EXT=1, unsigned otherwise) and to add the sat_flag output; ACC_BITS must
// then stay below 64.
module int_adder_tree_accumulator
  import int_acc_pkg::*;
#(
  parameter int IN_BITS   = 17,
  parameter int ACC_BITS  = 32,
  parameter int NUM_BEATS = 4,
  parameter int SIGN_EXT  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [IN_BITS-1:0]                   in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [ACC_BITS-1:0]                  out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
`ifdef INT_ACC_SATURATE_EN
  output logic                                 sat_flag,
`endif
  output logic [beat_cnt_bits(NUM_BEATS)-1:0]  beat_idx
);

  localparam int CW = beat_cnt_bits(NUM_BEATS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BEATS - 1);

  logic [ACC_BITS-1:0] acc;
  logic [ACC_BITS-1:0] ext;
  logic [ACC_BITS-1:0] sum;
  logic [CW-1:0]       cnt;
  logic                in_fire;
  logic                out_fire;
  logic                last_beat;

  // Input stalls only while a finished result is blocked downstream.
  assign in_ready  = !out_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_beat = (cnt == LAST_IDX);
  assign beat_idx  = cnt;

  // Widen the incoming partial sum to accumulator width.
  generate
    if (SIGN_EXT != 0) begin : g_sext
      assign ext = ACC_BITS'($signed(in_data));
    end else begin : g_zext
      assign ext = ACC_BITS'(in_data);
    end
  endgenerate

`ifdef INT_ACC_SATURATE_EN
  sat_res_t sres;
  logic     sum_clip;
  logic     grp_clip;
  logic     unused_sat_hi;

  // Clamped add of the running total and the new beat.
  always_comb begin
    if (SIGN_EXT != 0) begin
      sres = sat_add_s(word_t'(acc), word_t'(ext), ACC_BITS);
    end else begin
      sres = sat_add_u(word_t'(acc), word_t'(ext), ACC_BITS);
    end
  end

  assign sum           = sres.sum[ACC_BITS-1:0];
  assign sum_clip      = sres.clip;
  assign unused_sat_hi = ^sres.sum[SAT_W-1:ACC_BITS];

  // Remember any clip inside the current group until its result is loaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grp_clip <= 1'b0;
    end else if (in_fire) begin
      grp_clip <= last_beat ? 1'b0 : (grp_clip | sum_clip);
    end
  end
`else
  assign sum = acc + ext;
`endif

  // Running total and beat position; both restart after the last beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (in_fire) begin
      if (last_beat) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  int_acc_output_reg #(
    .W (ACC_BITS)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (in_fire && last_beat),
    .clear     (out_fire),
    .load_data (sum),
`ifdef INT_ACC_SATURATE_EN
    .load_flag (grp_clip | sum_clip),
    .sat_flag  (sat_flag),
`endif
    .out_data  (out_data),
    .out_valid (out_valid)
  );

endmodule

// File: tb/tb_int_adder_tree_accumulator.sv
// Three accumulators share one stimulus stream: signed 32-bit, zero-extended
// 32-bit and signed 18-bit. A group-level reference model predicts each result.
module tb_int_adder_tree_accumulator;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [16:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;

  logic        rdy_s, rdy_z, rdy_n;
  logic [31:0] data_s, data_z;
  logic [17:0] data_n;
  logic        val_s, val_z, val_n;
  logic [1:0]  idx_s, idx_z, idx_n;
`ifdef INT_ACC_SATURATE_EN
  logic        flag_s, flag_z, flag_n;
`endif

  int total = 0;
  int bad   = 0;
  bit rnd_mode = 1'b0;

  always #5 clk = ~clk;

  int_adder_tree_accumulator #(.IN_BITS(17), .ACC_BITS(32), .NUM_BEATS(NB), .SIGN_EXT(1)) u_s (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_s),
    .out_data(data_s), .out_valid(val_s), .out_ready(out_ready),
`ifdef INT_ACC_SATURATE_EN
    .sat_flag(flag_s),
`endif
    .beat_idx(idx_s));

  int_adder_tree_accumulator #(.IN_BITS(17), .ACC_BITS(32), .NUM_BEATS(NB), .SIGN_EXT(0)) u_z (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_z),
    .out_data(data_z), .out_valid(val_z), .out_ready(out_ready),
`ifdef INT_ACC_SATURATE_EN
    .sat_flag(flag_z),
`endif
    .beat_idx(idx_z));

  int_adder_tree_accumulator #(.IN_BITS(17), .ACC_BITS(18), .NUM_BEATS(NB), .SIGN_EXT(1)) u_n (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_n),
    .out_data(data_n), .out_valid(val_n), .out_ready(out_ready),
`ifdef INT_ACC_SATURATE_EN
    .sat_flag(flag_n),
`endif
    .beat_idx(idx_n));

  typedef struct {
    logic [31:0] s;
    logic [31:0] z;
    logic [17:0] n;
    logic        flag_n;
  } res_t;

  res_t        exp_q[$];
  logic [16:0] grp[$];
  bit          m_ready;

  // Group result straight from arithmetic on the beat values.
  function automatic res_t group_result(input logic [16:0] b[$]);
    res_t   r;
    longint s;
    longint z;
    longint a;
    bit     f;
    s = 0; z = 0; a = 0; f = 0;
    foreach (b[i]) begin
      s += longint'($signed(b[i]));
      z += longint'(b[i]);
      a += longint'($signed(b[i]));
`ifdef INT_ACC_SATURATE_EN
      if (a > 131071) begin a = 131071; f = 1; end
      else if (a < -131072) begin a = -131072; f = 1; end
`endif
    end
    r.s = 32'(s);
    r.z = 32'(z);
    r.n = 18'(a);
    r.flag_n = f;
    return r;
  endfunction

  // Reference: a queue of pending results plus the beats of the open group.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      grp.delete();
    end else begin
      m_ready = (exp_q.size() == 0) || out_ready;
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && m_ready) begin
        grp.push_back(in_data);
        if (grp.size() == NB) begin
          exp_q.push_back(group_result(grp));
          grp.delete();
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Continuous comparison of all three instances against the model.
  always @(negedge clk) begin
    chk("in_ready_s", 64'(rdy_s), 64'((exp_q.size() == 0) || out_ready));
    chk("in_ready_z", 64'(rdy_z), 64'((exp_q.size() == 0) || out_ready));
    chk("in_ready_n", 64'(rdy_n), 64'((exp_q.size() == 0) || out_ready));
    chk("out_valid_s", 64'(val_s), 64'(exp_q.size() != 0));
    chk("out_valid_z", 64'(val_z), 64'(exp_q.size() != 0));
    chk("out_valid_n", 64'(val_n), 64'(exp_q.size() != 0));
    chk("beat_idx_s", 64'(idx_s), 64'(grp.size()));
    chk("beat_idx_n", 64'(idx_n), 64'(grp.size()));
    if (exp_q.size() != 0) begin
      chk("out_data_s", 64'(data_s), 64'(exp_q[0].s));
      chk("out_data_z", 64'(data_z), 64'(exp_q[0].z));
      chk("out_data_n", 64'(data_n), 64'(exp_q[0].n));
`ifdef INT_ACC_SATURATE_EN
      chk("sat_flag_s", 64'(flag_s), 64'(0));
      chk("sat_flag_z", 64'(flag_z), 64'(0));
      chk("sat_flag_n", 64'(flag_n), 64'(exp_q[0].flag_n));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int v);
    int waited;
    bit took;
    waited = 0;
    took = 0;
    in_data = 17'(v);
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      took = (rdy_s === 1'b1);
      tick();
      waited++;
    end while (!took && waited < 50);
    in_valid = 1'b0;
    total++;
    assert (took) else begin
      bad++;
      $error("FAIL accept_timeout observed=not_accepted expected=accepted");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(val_s), 64'(0));
    chk("rst_data_s", 64'(data_s), 64'(0));
    chk("rst_data_z", 64'(data_z), 64'(0));
    chk("rst_data_n", 64'(data_n), 64'(0));
    chk("rst_idx", 64'(idx_s), 64'(0));
`ifdef INT_ACC_SATURATE_EN
    chk("rst_flag", 64'(flag_n), 64'(0));
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rst_ready", 64'(rdy_s), 64'(1));

    // Signed basic group
    send(5); send(-3); send(100); send(-2);
    chk("basic_valid", 64'(val_s), 64'(1));
    chk("basic_sum", 64'(data_s), 64'(32'd100));
    idle(1);
    chk("basic_one_cycle", 64'(val_s), 64'(0));

    // Back-to-back groups with no bubble
    for (int i = 1; i <= 8; i++) begin
      send(i);
      chk("b2b_ready", 64'(rdy_s), 64'(1));
      if (i == 4) chk("b2b_sum1", 64'(data_s), 64'(32'd10));
      if (i == 8) chk("b2b_sum2", 64'(data_s), 64'(32'd26));
    end
    idle(2);

    // Backpressure holds the result and stalls input
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(i);
    in_data = 17'd5;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_ready_low", 64'(rdy_s), 64'(0));
      chk("bp_hold_data", 64'(data_s), 64'(32'd10));
      chk("bp_hold_valid", 64'(val_s), 64'(1));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 5; i <= 8; i++) send(i);
    chk("bp_resume_sum", 64'(data_s), 64'(32'd26));
    idle(2);

    // Extension: all-ones beats
    repeat (4) send('h1FFFF);
    chk("zext_sum", 64'(data_z), 64'(32'h0007FFFC));
    chk("sext_sum", 64'(data_s), 64'(32'hFFFFFFFC));
    chk("sext18_sum", 64'(data_n), 64'(18'h3FFFC));
    idle(2);

    // Reset in the middle of a group
    send(7); send(7);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idx", 64'(idx_s), 64'(0));
    chk("midrst_valid", 64'(val_s), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) send(1);
    chk("midrst_sum", 64'(data_s), 64'(32'd4));
    idle(2);

    // Overflow of the 18-bit accumulator
    repeat (4) send('h0FFFF);
    chk("wide_sum", 64'(data_s), 64'(32'h0003FFFC));
`ifdef INT_ACC_SATURATE_EN
    chk("sat_sum", 64'(data_n), 64'(18'h1FFFF));
    chk("sat_flag", 64'(flag_n), 64'(1));
`else
    chk("wrap_sum", 64'(data_n), 64'(18'h3FFFC));
`endif
    idle(2);

    // Random beats, gaps and backpressure
    rnd_mode = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send(int'($urandom_range(0, 131071)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    idle(4);
    chk("drain_valid", 64'(val_s), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
